// File: rtl/bcd_to_xs3_serial_if.sv
// Serial BCD/Excess-3 link: bit stream in, coded bit stream plus digit status out.
interface bcd_to_xs3_serial_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             x;
    logic             en;
    logic             z;
    logic             digit_done;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output x, en,
        input  z, digit_done, err, err_cnt
    );

    modport slave (
        input  x, en,
        output z, digit_done, err, err_cnt
    );
endinterface

// File: rtl/bcd_to_xs3_serial.sv
// Bit-serial BCD to Excess-3 encoder (LSB first, Mealy output) with digit framing,
// non-BCD detection and a saturating invalid-digit counter.
module bcd_to_xs3_serial #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    bcd_to_xs3_serial_if.slave  bus
);

    // Bit position x carry of the running +0011 addition
    typedef enum logic [2:0] {
        S0, S1C0, S1C1, S2C0, S2C1, S3C0, S3C1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   z_c;
    logic   last_c;
    logic   bad_c;
    logic   b1;
    logic   b2;

    always_comb begin
        z_c       = 1'b0;
        state_nxt = state;
        last_c    = 1'b0;
        bad_c     = 1'b0;
        if (bus.en) begin
            case (state)
                S0: begin
                    z_c       = ~bus.x;
                    state_nxt = bus.x ? S1C1 : S1C0;
                end
                S1C0: begin
                    z_c       = ~bus.x;
                    state_nxt = bus.x ? S2C1 : S2C0;
                end
                S1C1: begin
                    z_c       = bus.x;
                    state_nxt = S2C1;
                end
                S2C0: begin
                    z_c       = bus.x;
                    state_nxt = S3C0;
                end
                S2C1: begin
                    z_c       = ~bus.x;
                    state_nxt = bus.x ? S3C1 : S3C0;
                end
                S3C0: begin
                    z_c       = bus.x;
                    state_nxt = S0;
                    last_c    = 1'b1;
                    bad_c     = bus.x & (b1 | b2);
                end
                S3C1: begin
                    z_c       = ~bus.x;
                    state_nxt = S0;
                    last_c    = 1'b1;
                    bad_c     = bus.x & (b1 | b2);
                end
                default: state_nxt = S0;
            endcase
        end
    end

    // Output is forced low while reset is asserted, independent of the clock
    assign bus.z = z_c & Rst;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state          <= S0;
            b1             <= 1'b0;
            b2             <= 1'b0;
            bus.digit_done <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            state          <= state_nxt;
            bus.digit_done <= last_c;
            bus.err        <= bad_c;
            if (bus.en && (state == S1C0 || state == S1C1)) begin
                b1 <= bus.x;
            end
            if (bus.en && (state == S2C0 || state == S2C1)) begin
                b2 <= bus.x;
            end
            if (bad_c && (bus.err_cnt != '1)) begin
                bus.err_cnt <= bus.err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
